ws2812b_pixel_assembler: RTL

Parametrised successor to the WS2812b byte assembler in the impostor_WS2812b peripheral. Consumes decoded bits (bit_valid/bit_value) from the bit decoder and packs them MSB-first into full pixels of BYTES_PER_PIXEL bytes (GRB = 3, GRBW = 4). Tags each pixel with its index within the frame and delivers it through a valid/ready output register. Handles the WS2812 latch/reset gap (frame_reset): aborts any partial pixel and reports the per-frame pixel count to the register block.

---
 rtl/ws2812b_pkg.sv | 21 ++
 rtl/ws2812b_out_reg.sv | 78 +++++++
 rtl/ws2812b_pixel_assembler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// ----------------------------------------------------------------------------
// ws2812b_pkg
//   Constants and helpers shared by the WS2812b receive path: the bit
//   decoder, the pixel assembler and the register block.
//
//   BYTES_GRB      bytes per pixel for plain RGB strips (G, R, B order)
//   BYTES_GRBW     bytes per pixel for RGBW strips (G, R, B, W order)
//   IDX_W_DEFAULT  default width of pixel index / frame pixel count
//   pixel_width()  pixel width in bits for a given byte count
// ----------------------------------------------------------------------------
package ws2812b_pkg;

  localparam int BYTES_GRB     = 3;
  localparam int BYTES_GRBW    = 4;
  localparam int IDX_W_DEFAULT = 8;

  function automatic int pixel_width(input int bytes_per_pixel);
    return 8 * bytes_per_pixel;
  endfunction

endpackage

// File: rtl/ws2812b_out_reg.sv
// ----------------------------------------------------------------------------
// ws2812b_out_reg
//   Single-entry valid/ready holding register for assembled pixels.
//
//   Handshake: the register offers o_data/o_index while o_valid is high. A
//   transfer happens in any cycle where o_valid && i_ready are both high at
//   the clock edge. While o_valid && !i_ready, o_data/o_index hold steady.
//   The slot counts as free when it is empty or is being drained this cycle,
//   so a new entry can load in the same cycle an old one leaves (no bubble).
//   A load offered while the slot is not free is dropped and raises the
//   sticky o_overflow; the held entry is left untouched.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   i_load             one-cycle strobe: candidate entry available
//   i_data, i_index    candidate entry payload and tag
//   i_ready            consumer accepts the held entry
//   i_clear_overflow   clears o_overflow (a same-cycle drop wins)
//   o_valid            register holds an entry
//   o_data, o_index    held entry
//   o_overflow         sticky: a candidate was dropped
// ----------------------------------------------------------------------------
module ws2812b_out_reg #(
  parameter int DATA_W = 24,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_index,
  input  logic              i_ready,
  input  logic              i_clear_overflow,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_overflow
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_index;
  logic              r_overflow;
  logic              w_free;

  assign w_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
    end else if (i_load && w_free) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_index <= i_index;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Set takes priority over clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_load && !w_free) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_index    = r_index;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ws2812b_pixel_assembler.sv
// ----------------------------------------------------------------------------
// ws2812b_pixel_assembler
//   Packs decoded WS2812b bits MSB-first into pixels of BYTES_PER_PIXEL bytes
//   (legal 1..4), tags each pixel with its index within the frame and hands
//   it out through a single-entry valid/ready register. A frame_reset (latch
//   gap) aborts any partial pixel, restarts indexing and publishes the number
//   of pixels completed in the frame that just ended.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   bit_valid        one-cycle strobe: decoded bit available
//   bit_value        decoded bit value
//   frame_reset      one-cycle strobe: latch gap (wins over bit_valid)
//   clear_overflow   clears the overflow flag
//   pixel_valid      output register holds a pixel
//   pixel_ready      consumer accepts pixel when high with pixel_valid
//   pixel_data       assembled pixel, first received bit at MSB
//   pixel_index      index of pixel within its frame
//   overflow         sticky: a completed pixel was dropped
//   frame_done       one-cycle pulse after frame_reset
//   frame_pixels     pixels completed in last frame (saturating)
//   partial_drop     one-cycle pulse: frame_reset discarded a partial pixel
//
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ws2812b_pixel_assembler
  import ws2812b_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = BYTES_GRB,
  parameter int IDX_W           = IDX_W_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      bit_valid,
  input  logic                                      bit_value,
  input  logic                                      frame_reset,
  input  logic                                      clear_overflow,
  output logic                                      pixel_valid,
  input  logic                                      pixel_ready,
  output logic [pixel_width(BYTES_PER_PIXEL)-1:0]   pixel_data,
  output logic [IDX_W-1:0]                          pixel_index,
  output logic                                      overflow,
  output logic                                      frame_done,
  output logic [IDX_W-1:0]                          frame_pixels,
  output logic                                      partial_drop
);

  localparam int PIXEL_W = pixel_width(BYTES_PER_PIXEL);
  localparam int CNT_W   = $clog2(PIXEL_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIXEL_W - 1);

  logic [CNT_W-1:0]   r_bit_cnt;
  // Only the low PIXEL_W-1 bits of history are ever needed: the final bit
  // of a pixel is taken straight from bit_value.
  logic [PIXEL_W-2:0] r_shift;
  logic [IDX_W-1:0]   r_index;
  logic [IDX_W-1:0]   r_frame_cnt;
  logic [IDX_W-1:0]   r_frame_pixels;
  logic               r_frame_done;
  logic               r_partial_drop;

  logic               w_bit_take;
  logic               w_complete;
  logic [PIXEL_W-1:0] w_candidate;

  // A bit arriving with frame_reset is discarded.
  assign w_bit_take  = bit_valid && !frame_reset;
  assign w_complete  = w_bit_take && (r_bit_cnt == LAST_BIT);
  assign w_candidate = {r_shift, bit_value};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_index        <= '0;
      r_frame_cnt    <= '0;
      r_frame_pixels <= '0;
      r_frame_done   <= 1'b0;
      r_partial_drop <= 1'b0;
    end else if (frame_reset) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_index        <= '0;
      r_frame_cnt    <= '0;
      r_frame_pixels <= r_frame_cnt;
      r_frame_done   <= 1'b1;
      r_partial_drop <= (r_bit_cnt != '0);
    end else begin
      r_frame_done   <= 1'b0;
      r_partial_drop <= 1'b0;
      if (bit_valid) begin
        r_shift <= w_candidate[PIXEL_W-2:0];
        if (w_complete) begin
          r_bit_cnt <= '0;
          // Every completed pixel advances the index and the frame count,
          // whether or not the output register could take it.
          r_index   <= r_index + 1'b1;
          if (r_frame_cnt != '1) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  ws2812b_out_reg #(
    .DATA_W (PIXEL_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_load           (w_complete),
    .i_data           (w_candidate),
    .i_index          (r_index),
    .i_ready          (pixel_ready),
    .i_clear_overflow (clear_overflow),
    .o_valid          (pixel_valid),
    .o_data           (pixel_data),
    .o_index          (pixel_index),
    .o_overflow       (overflow)
  );

  assign frame_done   = r_frame_done;
  assign frame_pixels = r_frame_pixels;
  assign partial_drop = r_partial_drop;

endmodule
